// File: rtl/bus_cycle_sequencer.sv
// Bus-cycle controller: runs each core request as an 8 T-state bus cycle
// (T0..T7) with wait states at T6, hold freezing, and a timeout error.
module bus_cycle_sequencer #(
    parameter int WIDTH    = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             we,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             hold,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] rdata_bus,
    output logic             req_ready,
    output logic [WIDTH-1:0] ADDR,
    output logic [WIDTH-1:0] wdata_bus,
    output logic [2:0]       t_state,
    output logic             busint,
    output logic             dtr_,
    output logic             stall_,
    output logic             ack,
    output logic [WIDTH-1:0] rdata,
    output logic             err
);

    localparam int CW = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(WAIT_MAX);

    typedef enum logic [1:0] {IDLE, RUN, WAIT, LAST} state_t;

    state_t        state_reg;
    logic [CW-1:0] wait_cnt_reg;

    assign req_ready = ((state_reg == IDLE) || (state_reg == LAST)) && !hold;
    assign stall_    = ~hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            t_state      <= 3'd0;
            busint       <= 1'b0;
            dtr_         <= 1'b1;
            ack          <= 1'b0;
            err          <= 1'b0;
            ADDR         <= '0;
            wdata_bus    <= '0;
            rdata        <= '0;
        end else if (!hold) begin
            // hold freezes everything, including a pending ack in LAST
            case (state_reg)
                IDLE, LAST: begin
                    ack <= 1'b0;
                    if (req) begin
                        ADDR         <= addr;
                        wdata_bus    <= wdata;
                        dtr_         <= ~we;
                        busint       <= 1'b1;
                        t_state      <= 3'd0;
                        wait_cnt_reg <= '0;
                        state_reg    <= RUN;
                    end else begin
                        busint    <= 1'b0;
                        t_state   <= 3'd0;
                        dtr_      <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    t_state <= t_state + 3'd1;
                    if (t_state == 3'd5) begin
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ready) begin
                        if (dtr_) begin
                            rdata <= rdata_bus;
                        end
                        err       <= 1'b0;
                        ack       <= 1'b1;
                        t_state   <= 3'd7;
                        state_reg <= LAST;
                    end else if (wait_cnt_reg < WAIT_LIMIT) begin
                        wait_cnt_reg <= wait_cnt_reg + CW'(1);
                    end else begin
                        err       <= 1'b1;
                        ack       <= 1'b1;
                        t_state   <= 3'd7;
                        state_reg <= LAST;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
